// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - Mode 0 SPI initiator: byte handshake in, SCLK/PICO/CS_n out, POCI bytes back.
module spi_controller #(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_SETUP_CLKS     = 2,
    parameter int CS_IDLE_CLKS      = 2
) (
    input  logic       i_SPI_CLK,
    input  logic       i_rst,
    input  logic       i_txDataValid,
    input  logic [7:0] i_txData,
    input  logic       i_txLast,
    output logic       o_txReady,
    output logic       o_rxDataValid,
    output logic [7:0] o_rxData,
    output logic       o_busy,
    output logic       o_SPI_CLK,
    output logic       o_SPI_PICO,
    input  logic       i_SPI_POCI,
    output logic       o_SPI_CS_n
);
    localparam int CW = 16;
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CLKS - 1);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE_CLKS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, DEASSERT} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [3:0]      k, k_n;
    logic [7:0]      tx_sr, tx_sr_n, rx_sr, rx_sr_n;
    logic            last_q, last_n, done, done_n;
    logic            sclk_n, pico_n, cs_n_n, ready_n;
    logic            accept;

    assign accept = i_txDataValid && o_txReady;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        k_n     = k;
        tx_sr_n = tx_sr;
        rx_sr_n = rx_sr;
        last_n  = last_q;
        done_n  = 1'b0;
        sclk_n  = o_SPI_CLK;
        pico_n  = o_SPI_PICO;
        cs_n_n  = o_SPI_CS_n;
        ready_n = o_txReady;
        case (state)
            IDLE: begin
                cs_n_n  = 1'b1;
                sclk_n  = 1'b0;
                pico_n  = 1'b0;
                ready_n = 1'b1;
                if (accept) begin
                    state_n = SETUP;
                    ready_n = 1'b0;
                    cs_n_n  = 1'b0;
                    pico_n  = i_txData[7];
                    tx_sr_n = i_txData;
                    last_n  = i_txLast;
                    cnt_n   = '0;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    k_n     = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt != HALF_LAST) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                    if (k == 4'd15) begin
                        // 8th falling edge: byte complete, rx pulse follows one cycle later
                        sclk_n = 1'b0;
                        done_n = 1'b1;
                        if (last_q) begin
                            state_n = DEASSERT;
                            cs_n_n  = 1'b1;
                            pico_n  = 1'b0;
                        end else begin
                            state_n = NEXT;
                            ready_n = 1'b1;
                        end
                    end else begin
                        k_n = k + 1'b1;
                        if (!k[0]) begin
                            sclk_n  = 1'b1;
                            rx_sr_n = {rx_sr[6:0], i_SPI_POCI};
                        end else begin
                            sclk_n  = 1'b0;
                            pico_n  = tx_sr[6];
                            tx_sr_n = {tx_sr[6:0], 1'b0};
                        end
                    end
                end
            end
            NEXT: begin
                // Re-entering SHIFT at k=0 gives the low half-period carrying the new MSB
                if (accept) begin
                    state_n = SHIFT;
                    ready_n = 1'b0;
                    k_n     = '0;
                    cnt_n   = '0;
                    pico_n  = i_txData[7];
                    tx_sr_n = i_txData;
                    last_n  = i_txLast;
                end
            end
            DEASSERT: begin
                if (cnt == IDLE_LAST) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_SPI_CLK or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            k             <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            last_q        <= 1'b0;
            done          <= 1'b0;
            o_SPI_CLK     <= 1'b0;
            o_SPI_PICO    <= 1'b0;
            o_SPI_CS_n    <= 1'b1;
            o_txReady     <= 1'b0;
            o_rxDataValid <= 1'b0;
            o_rxData      <= '0;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            k             <= k_n;
            tx_sr         <= tx_sr_n;
            rx_sr         <= rx_sr_n;
            last_q        <= last_n;
            done          <= done_n;
            o_SPI_CLK     <= sclk_n;
            o_SPI_PICO    <= pico_n;
            o_SPI_CS_n    <= cs_n_n;
            o_txReady     <= ready_n;
            o_rxDataValid <= done;
            if (done) o_rxData <= rx_sr;
            o_busy        <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - randomized self-checking bench for spi_controller with a peripheral model.
module tb_spi_controller;
    localparam int H = 2;
    localparam int S = 2;
    localparam int I = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic       last = 1'b0;
    logic [7:0] data = 8'h00;
    logic       loop = 1'b1;
    logic       ready, rx_valid, busy, sclk, pico, poci, cs_n;
    logic [7:0] rx_data;

    spi_controller #(.CLKS_PER_HALF_BIT(H), .CS_SETUP_CLKS(S), .CS_IDLE_CLKS(I)) dut (
        .i_SPI_CLK(clk), .i_rst(rst), .i_txDataValid(valid), .i_txData(data), .i_txLast(last),
        .o_txReady(ready), .o_rxDataValid(rx_valid), .o_rxData(rx_data), .o_busy(busy),
        .o_SPI_CLK(sclk), .o_SPI_PICO(pico), .i_SPI_POCI(poci), .o_SPI_CS_n(cs_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int cs_rise_cyc = 0;
    int cs_rise_cnt = 0;
    int ready_rise_cyc = 0;
    logic prev_cs = 1'b1;
    logic prev_ready = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_cyc_q[$];
    logic       pico_q[$];

    // Peripheral: shifts preloaded bytes MSB first, advancing after each SCLK rise while CS_n is low
    logic [7:0] periph [4];
    logic [4:0] prise = 5'd0;
    logic [7:0] cur_byte;
    assign cur_byte = periph[prise[4:3]];
    assign poci = loop ? pico : cur_byte[3'd7 - prise[2:0]];

    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) prise <= 5'd0;
        else      prise <= prise + 5'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge sclk) pico_q.push_back(pico);

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rx_cyc_q.push_back(cyc);
        end
        if (cs_n && !prev_cs) begin
            cs_rise_cyc = cyc;
            cs_rise_cnt++;
        end
        if (ready && !prev_ready) ready_rise_cyc = cyc;
        prev_cs = cs_n;
        prev_ready = ready;
    end

    task automatic drive(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            n_cmp++; n_bad++;
            $display("FAIL drive_ready: ready=%b required 1 within 500 cycles", ready);
        end
        valid = 1'b1; data = d; last = l;
        acc_cyc = cyc + 1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        do begin
            @(negedge clk); #1;
            t++;
        end while (rx_q.size() < n && t < 2000);
        if (rx_q.size() < n) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_rx: got %0d bytes required %0d", rx_q.size(), n);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        do begin
            @(negedge clk); #1;
            t++;
        end while (!ready && t < 500);
        if (!ready) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_ready: ready=%b required 1", ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if ({cs_n, sclk, pico, ready, busy, rx_valid} !== 6'b100000) begin n_bad++;
            $display("FAIL reset_outputs: cs,sclk,pico,ready,busy,rxv=%b required 100000", {cs_n, sclk, pico, ready, busy, rx_valid}); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++;
            $display("FAIL reset_rxdata: got %h required 00", rx_data); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++;
            $display("FAIL reset_ready_release: got %b required 0", ready); end
        @(negedge clk); #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++;
            $display("FAIL reset_ready_edge: got %b required 1", ready); end
    endtask

    task automatic test_loopback();
        logic [7:0] b;
        int base, bad;
        loop = 1'b1;
        for (int t = 0; t < 4; t++) begin
            b = (t == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            pico_q.delete();
            base = rx_q.size();
            drive(b, 1'b1);
            wait_rx(base + 1);
            if (rx_q.size() > base) begin
                n_cmp++; if (rx_q[base] !== b) begin n_bad++;
                    $display("FAIL loop_rx: got %h required %h", rx_q[base], b); end
                n_cmp++; if (rx_cyc_q[base] - acc_cyc != 1 + S + 16 * H) begin n_bad++;
                    $display("FAIL loop_latency: got %0d required %0d", rx_cyc_q[base] - acc_cyc, 1 + S + 16 * H); end
            end
            n_cmp++; if (pico_q.size() != 8) begin n_bad++;
                $display("FAIL loop_rises: got %0d required 8", pico_q.size()); end
            bad = 0;
            for (int i = 0; i < 8 && i < pico_q.size(); i++) if (pico_q[i] !== b[7-i]) bad++;
            n_cmp++; if (bad != 0) begin n_bad++;
                $display("FAIL loop_pico_bits: %0d wrong bits for %h", bad, b); end
            wait_ready();
            n_cmp++; if (ready_rise_cyc - cs_rise_cyc != I) begin n_bad++;
                $display("FAIL loop_cs_idle: got %0d cycles required %0d", ready_rise_cyc - cs_rise_cyc, I); end
        end
    endtask

    task automatic test_burst();
        logic [7:0] b0, b1, tx;
        int base, rises0, bad;
        loop = 1'b0;
        periph[0] = 8'($urandom_range(0, 255));
        periph[1] = 8'($urandom_range(0, 255));
        pico_q.delete();
        base = rx_q.size();
        rises0 = cs_rise_cnt;
        b0 = 8'h3C; b1 = 8'hC3;
        drive(b0, 1'b0);
        drive(b1, 1'b1);
        wait_rx(base + 2);
        if (rx_q.size() >= base + 2) begin
            n_cmp++; if (rx_q[base] !== periph[0] || rx_q[base+1] !== periph[1]) begin n_bad++;
                $display("FAIL burst_rx: got %h %h required %h %h", rx_q[base], rx_q[base+1], periph[0], periph[1]); end
            n_cmp++; if (rx_cyc_q[base+1] - acc_cyc != 1 + 16 * H) begin n_bad++;
                $display("FAIL burst_next_latency: got %0d required %0d", rx_cyc_q[base+1] - acc_cyc, 1 + 16 * H); end
        end
        wait_ready();
        n_cmp++; if (cs_rise_cnt - rises0 != 1) begin n_bad++;
            $display("FAIL burst_cs_low: cs rose %0d times required 1", cs_rise_cnt - rises0); end
        n_cmp++; if (pico_q.size() != 16) begin n_bad++;
            $display("FAIL burst_rises: got %0d required 16", pico_q.size()); end
        bad = 0;
        for (int i = 0; i < 16 && i < pico_q.size(); i++) begin
            tx = (i < 8) ? b0 : b1;
            if (pico_q[i] !== tx[7 - (i % 8)]) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++;
            $display("FAIL burst_pico_bits: %0d wrong bits", bad); end
    endtask

    task automatic test_zero_tx();
        int base, ones;
        loop = 1'b0;
        periph[0] = 8'h5A;
        pico_q.delete();
        base = rx_q.size();
        drive(8'h00, 1'b1);
        wait_rx(base + 1);
        if (rx_q.size() > base) begin
            n_cmp++; if (rx_q[base] !== 8'h5A) begin n_bad++;
                $display("FAIL zero_rx: got %h required 5a", rx_q[base]); end
        end
        ones = 0;
        foreach (pico_q[i]) if (pico_q[i] !== 1'b0) ones++;
        n_cmp++; if (ones != 0 || pico_q.size() != 8) begin n_bad++;
            $display("FAIL zero_pico: %0d high of %0d rises required 0 of 8", ones, pico_q.size()); end
        wait_ready();
    endtask

    task automatic test_reset_mid();
        int base, t;
        loop = 1'b1;
        pico_q.delete();
        base = rx_q.size();
        drive(8'h77, 1'b1);
        t = 0;
        while (pico_q.size() < 3 && t < 500) begin
            @(negedge clk);
            t++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({cs_n, sclk, pico, ready} !== 4'b1000) begin n_bad++;
            $display("FAIL midreset_outputs: cs,sclk,pico,ready=%b required 1000", {cs_n, sclk, pico, ready}); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        n_cmp++; if (rx_q.size() != base || pico_q.size() != 3) begin n_bad++;
            $display("FAIL midreset_discard: rx count %0d rises %0d required %0d and 3", rx_q.size(), pico_q.size(), base); end
        pico_q.delete();
        drive(8'h81, 1'b1);
        wait_rx(base + 1);
        if (rx_q.size() > base) begin
            n_cmp++; if (rx_q[base] !== 8'h81 || rx_cyc_q[base] - acc_cyc != 1 + S + 16 * H) begin n_bad++;
                $display("FAIL midreset_next: got %h latency %0d required 81 latency %0d", rx_q[base], rx_cyc_q[base] - acc_cyc, 1 + S + 16 * H); end
        end
        wait_ready();
    endtask

    task automatic test_stall();
        logic [7:0] b1, b2;
        int base, bad;
        loop = 1'b1;
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        pico_q.delete();
        base = rx_q.size();
        drive(b1, 1'b0);
        valid = 1'b1; data = ~b1; last = 1'b1;
        repeat (10) @(negedge clk);
        valid = 1'b0;
        wait_rx(base + 1);
        bad = 0;
        repeat (50) begin
            @(negedge clk); #1;
            if (cs_n !== 1'b0 || sclk !== 1'b0 || ready !== 1'b1 || busy !== 1'b1 || pico !== b1[0]) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++;
            $display("FAIL stall_hold: %0d bad cycles of 50 required 0", bad); end
        drive(b2, 1'b1);
        wait_rx(base + 2);
        if (rx_q.size() >= base + 2) begin
            n_cmp++; if (rx_q[base] !== b1 || rx_q[base+1] !== b2) begin n_bad++;
                $display("FAIL stall_rx: got %h %h required %h %h", rx_q[base], rx_q[base+1], b1, b2); end
        end
        n_cmp++; if (pico_q.size() != 16) begin n_bad++;
            $display("FAIL stall_rises: got %0d required 16", pico_q.size()); end
        wait_ready();
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_burst();
        test_zero_tx();
        test_reset_mid();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
